// File: rtl/vt_i2c_pkg.sv
// rtl/vt_i2c_pkg.sv - shared constants, types and character decode for the I2C waveform driver
package vt_i2c_pkg;

   localparam int TW = 16;

   localparam logic [7:0] CH_0 = 8'h30;
   localparam logic [7:0] CH_1 = 8'h31;
   localparam logic [7:0] CH_L = 8'h4C;
   localparam logic [7:0] CH_H = 8'h48;
   localparam logic [7:0] CH_X = 8'h58;
   localparam logic [7:0] CH_Z = 8'h5A;

   typedef struct packed {
      logic oe;
      logic cmp_en;
      logic exp;
   } wfc_act_t;

   typedef enum logic {IDLE, RUN} drv_state_t;

   // Unknown characters fall through to the all-zero action, which is exactly 'X'.
   function automatic wfc_act_t wfc_decode(input logic [7:0] ch);
      wfc_act_t a;
      a = '0;
      case (ch)
         CH_0:    a.oe = 1'b1;
         CH_L:    a.cmp_en = 1'b1;
         CH_H:    begin a.cmp_en = 1'b1; a.exp = 1'b1; end
         default: a = '0;
      endcase
      return a;
   endfunction

   function automatic logic wfc_known(input logic [7:0] ch);
      return (ch == CH_0) || (ch == CH_1) || (ch == CH_L) ||
             (ch == CH_H) || (ch == CH_X) || (ch == CH_Z);
   endfunction

endpackage

// File: rtl/vt_i2c_timing_table.sv
// rtl/vt_i2c_timing_table.sv - per-wft drive/strobe tick register file
module vt_i2c_timing_table #(
   parameter int TBL_DEPTH = 16,
   parameter int TW        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [3:0]    i_waddr,
   input  logic [TW-1:0] i_drive_t,
   input  logic [TW-1:0] i_strobe_t,
   input  logic [3:0]    i_raddr,
   output logic [TW-1:0] o_drive_t,
   output logic [TW-1:0] o_strobe_t
);

   logic [TW-1:0] r_drive  [TBL_DEPTH];
   logic [TW-1:0] r_strobe [TBL_DEPTH];

   // An all-ones strobe tick can never be reached, so reset entries never compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TBL_DEPTH; i++) begin
            r_drive[i]  <= '0;
            r_strobe[i] <= '1;
         end
      end else if (i_we) begin
         r_drive[i_waddr]  <= i_drive_t;
         r_strobe[i_waddr] <= i_strobe_t;
      end
   end

   assign o_drive_t  = r_drive[i_raddr];
   assign o_strobe_t = r_strobe[i_raddr];

endmodule

// File: rtl/vt_i2c_wfc_driver.sv
// rtl/vt_i2c_wfc_driver.sv - turns I2C vectors into timed open-drain drive and strobe compares
module vt_i2c_wfc_driver #(
   parameter int TBL_DEPTH = 16,
   parameter int TW        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [TW-1:0] cfg_drive_t,
   input  logic [TW-1:0] cfg_strobe_t,
   input  logic          vec_valid,
   output logic          vec_ready,
   input  logic [3:0]    vec_wft,
   input  logic [15:0]   vec_wfc,
   input  logic [TW-1:0] vec_period,
   input  logic [TW-1:0] vec_repeat,
   input  logic [31:0]   vec_num,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          scl_oe,
   output logic          sda_oe,
   output logic          busy,
   output logic          fail,
   output logic [15:0]   fail_cnt,
   output logic [31:0]   first_fail_num,
   output logic          bad_wfc
);

   import vt_i2c_pkg::*;

   logic [TW-1:0] w_tbl_drive;
   logic [TW-1:0] w_tbl_strobe;

   drv_state_t    r_state;
   logic [TW-1:0] r_tick;
   logic [TW-1:0] r_rep;
   logic [TW-1:0] r_per;
   logic [TW-1:0] r_drive_t;
   logic [TW-1:0] r_strobe_t;
   wfc_act_t      r_scl_act;
   wfc_act_t      r_sda_act;
   logic [31:0]   r_num;
   logic [1:0]    r_scl_sync;
   logic [1:0]    r_sda_sync;
   logic          r_scl_oe;
   logic          r_sda_oe;
   logic          r_fail;
   logic [15:0]   r_fail_cnt;
   logic [31:0]   r_first_fail;
   logic          r_bad_wfc;

   vt_i2c_timing_table #(
      .TBL_DEPTH (TBL_DEPTH),
      .TW        (TW)
   ) u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (cfg_we),
      .i_waddr    (cfg_addr),
      .i_drive_t  (cfg_drive_t),
      .i_strobe_t (cfg_strobe_t),
      .i_raddr    (vec_wft),
      .o_drive_t  (w_tbl_drive),
      .o_strobe_t (w_tbl_strobe)
   );

   logic          w_last_tick;
   logic          w_ready;
   logic          w_accept;
   logic [TW-1:0] w_per_eff;
   logic [TW-1:0] w_rep_eff;
   logic          w_drive_hit;
   logic          w_strobe_hit;
   logic          w_mism;
   logic          w_wfc_ok;

   assign w_last_tick  = (r_tick == r_per - TW'(1));
   assign w_ready      = (r_state == IDLE) || (w_last_tick && (r_rep == '0));
   assign w_accept     = vec_valid && w_ready;
   assign w_per_eff    = (vec_period == '0) ? TW'(1) : vec_period;
   assign w_rep_eff    = (vec_repeat == '0) ? '0 : vec_repeat - TW'(1);
   assign w_drive_hit  = (r_state == RUN) && (r_tick == r_drive_t);
   assign w_strobe_hit = (r_state == RUN) && (r_tick == r_strobe_t);
   assign w_mism       = (r_scl_act.cmp_en && (r_scl_sync[1] != r_scl_act.exp)) ||
                         (r_sda_act.cmp_en && (r_sda_sync[1] != r_sda_act.exp));
   assign w_wfc_ok     = wfc_known(vec_wfc[15:8]) && wfc_known(vec_wfc[7:0]);

   // Idle bus level is high, so the synchronizers reset to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_in};
         r_sda_sync <= {r_sda_sync[0], sda_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_tick       <= '0;
         r_rep        <= '0;
         r_per        <= TW'(1);
         r_drive_t    <= '0;
         r_strobe_t   <= '1;
         r_scl_act    <= '0;
         r_sda_act    <= '0;
         r_num        <= '0;
         r_scl_oe     <= 1'b0;
         r_sda_oe     <= 1'b0;
         r_fail       <= 1'b0;
         r_fail_cnt   <= '0;
         r_first_fail <= '0;
         r_bad_wfc    <= 1'b0;
      end else begin
         r_fail <= 1'b0;
         if (w_drive_hit) begin
            r_scl_oe <= r_scl_act.oe;
            r_sda_oe <= r_sda_act.oe;
         end
         // Both pins failing in the same strobe still counts as a single failing cycle.
         if (w_strobe_hit && w_mism) begin
            r_fail <= 1'b1;
            if (r_fail_cnt != 16'hFFFF) r_fail_cnt <= r_fail_cnt + 16'd1;
            if (r_fail_cnt == '0) r_first_fail <= r_num;
         end
         if (w_accept) begin
            r_state    <= RUN;
            r_tick     <= '0;
            r_rep      <= w_rep_eff;
            r_per      <= w_per_eff;
            r_drive_t  <= w_tbl_drive;
            r_strobe_t <= w_tbl_strobe;
            r_scl_act  <= wfc_decode(vec_wfc[15:8]);
            r_sda_act  <= wfc_decode(vec_wfc[7:0]);
            r_num      <= vec_num;
            if (!w_wfc_ok) r_bad_wfc <= 1'b1;
         end else if (r_state == RUN) begin
            if (w_last_tick) begin
               if (r_rep != '0) begin
                  r_tick <= '0;
                  r_rep  <= r_rep - TW'(1);
               end else begin
                  r_state <= IDLE;
               end
            end else begin
               r_tick <= r_tick + TW'(1);
            end
         end
      end
   end

   assign vec_ready      = w_ready;
   assign busy           = (r_state == RUN);
   assign scl_oe         = r_scl_oe;
   assign sda_oe         = r_sda_oe;
   assign fail           = r_fail;
   assign fail_cnt       = r_fail_cnt;
   assign first_fail_num = r_first_fail;
   assign bad_wfc        = r_bad_wfc;

endmodule
